// File: rtl/rv_wb_pkg.sv
// Shared types and helpers for the writeback unit.
//   XLEN        default datapath width
//   F3_*        load funct3 encodings understood by the load extender
//   wb_entry_t  one buffered ALU result (destination register + data)
//   load_extend selects the byte/half/word from an aligned memory word and
//               sign- or zero-extends it according to funct3
package rv_wb_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  // Half-word selection uses only off[1]; a misaligned half offset is
  // rounded down to the containing half-word.
  function automatic logic [XLEN-1:0] load_extend(input logic [2:0]      funct3,
                                                  input logic [XLEN-1:0] rdata,
                                                  input logic [1:0]      off);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    byte_v = rdata[8*off +: 8];
    half_v = rdata[16*off[1] +: 16];
    case (funct3)
      F3_LB:   return {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LH:   return {{(XLEN-16){half_v[15]}}, half_v};
      F3_LBU:  return {{(XLEN-8){1'b0}}, byte_v};
      F3_LHU:  return {{(XLEN-16){1'b0}}, half_v};
      default: return rdata;  // LW and any unused code
    endcase
  endfunction

endpackage

// File: rtl/rv_wb_fifo.sv
// In-order synchronous FIFO of wb_entry_t used to buffer ALU results while
// the write port is busy with loads or earlier buffered results.
//   clk, reset      clock, synchronous active-high reset (empties the FIFO)
//   push_i, data_i  write one entry (caller guarantees !full_o)
//   pop_i           drop the head entry (caller guarantees !empty_o)
//   head_o          current head entry, valid while !empty_o
//   full_o, empty_o occupancy flags
module rv_wb_fifo
  import rv_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push_i,
  input  wb_entry_t data_i,
  input  logic      pop_i,
  output wb_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  wb_entry_t   mem_q [DEPTH];

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_i};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_i};

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of block ordering.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and an unreset array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/rv_wb_unit.sv
// Writeback stage: arbitrates load data and ALU results onto the integer
// register file write port and tracks outstanding writes for RAW stalls.
//   clk, reset                      clock, synchronous active-high reset
//   alu_valid/ready/rd/data         ALU result handshake (buffered)
//   lsu_valid/ready/rd/rdata/
//   lsu_funct3/lsu_byte_off         load data, never back-pressured
//   iss_valid, iss_rd               issue of an instruction with a destination
//   pending                         scoreboard of outstanding writes
//   wr_data, wr_addr, we, reg_sel   registered register-file write port
module rv_wb_unit #(
  parameter int XLEN           = rv_wb_pkg::XLEN,
  parameter int ALU_FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_rdata,
  input  logic [2:0]      lsu_funct3,
  input  logic [1:0]      lsu_byte_off,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  output logic [31:0]     pending,
  output logic [XLEN-1:0] wr_data,
  output logic [4:0]      wr_addr,
  output logic            we,
  output logic            reg_sel
);

  import rv_wb_pkg::*;

  logic            we_q, we_d;
  logic [4:0]      wr_addr_q, wr_addr_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;
  logic [31:0]     pending_q, pending_d;

  logic      fifo_push, fifo_pop, fifo_full, fifo_empty;
  wb_entry_t fifo_head, fifo_in;
  logic      alu_acc, alu_live;

  rv_wb_fifo #(.DEPTH(ALU_FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .data_i  (fifo_in),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign alu_ready = ~fifo_full;
  assign lsu_ready = ~reset;
  assign alu_acc   = alu_valid & alu_ready;
  // rd=0 results are consumed on acceptance and never occupy the FIFO.
  assign alu_live  = alu_acc & (alu_rd != 5'd0);
  assign fifo_in   = '{rd: alu_rd, data: alu_data};

  // Priority: load > FIFO head > ALU bypass. An accepted ALU result loses
  // only to the first two, in which case it is buffered.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    we_d      = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (lsu_valid) begin
      we_d      = (lsu_rd != 5'd0);
      wr_addr_d = lsu_rd;
      wr_data_d = load_extend(lsu_funct3, lsu_rdata, lsu_byte_off);
      fifo_push = alu_live;
    end else if (!fifo_empty) begin
      fifo_pop  = 1'b1;
      we_d      = 1'b1;
      wr_addr_d = fifo_head.rd;
      wr_data_d = fifo_head.data;
      fifo_push = alu_live;
    end else if (alu_acc) begin
      we_d      = alu_live;
      wr_addr_d = alu_rd;
      wr_data_d = alu_data;
    end
  end

  // Clear on commit first, then set on issue, so a same-edge issue wins.
  always_comb begin
    pending_d = pending_q;
    if (we_q) pending_d[wr_addr_q] = 1'b0;
    if (iss_valid && iss_rd != 5'd0) pending_d[iss_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      pending_q <= '0;
    end else begin
      we_q      <= we_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      pending_q <= pending_d;
    end
  end

  assign we      = we_q;
  assign reg_sel = we_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_rv_wb_unit.sv
// Directed testbench for rv_wb_unit with hand-computed expected values.
module tb_rv_wb_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_rdata;
  logic [2:0]  lsu_funct3;
  logic [1:0]  lsu_byte_off;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [31:0] pending;
  logic [31:0] wr_data;
  logic [4:0]  wr_addr;
  logic        we, reg_sel;

  int n_checks = 0;
  int n_errors = 0;

  rv_wb_unit #(.XLEN(32), .ALU_FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .lsu_valid    (lsu_valid),
    .lsu_ready    (lsu_ready),
    .lsu_rd       (lsu_rd),
    .lsu_rdata    (lsu_rdata),
    .lsu_funct3   (lsu_funct3),
    .lsu_byte_off (lsu_byte_off),
    .iss_valid    (iss_valid),
    .iss_rd       (iss_rd),
    .pending      (pending),
    .wr_data      (wr_data),
    .wr_addr      (wr_addr),
    .we           (we),
    .reg_sel      (reg_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are then stable for sampling
  // and inputs can be changed for the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_rdata = 0; lsu_funct3 = 0; lsu_byte_off = 0;
    iss_valid = 0; iss_rd = 0;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [1:0] off,
                         input logic [31:0] rdata, input logic [31:0] exp);
    lsu_valid = 1; lsu_rd = 5'd9; lsu_funct3 = f3; lsu_byte_off = off; lsu_rdata = rdata;
    tick();
    check({tag, "_we"}, we, 1);
    check(tag, wr_data, exp);
    lsu_valid = 0;
    tick();
  endtask

  logic [4:0]  exp_rd   [5];
  logic [31:0] exp_data [5];

  initial begin
    int sent, drained, writes;
    logic rdy;
    idle_inputs();
    reset = 1;
    tick(); tick();
    check("rst_we", we, 0);
    check("rst_reg_sel", reg_sel, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_pending", pending, 0);
    check("rst_lsu_ready", lsu_ready, 0);
    reset = 0;
    #1;
    check("post_rst_lsu_ready", lsu_ready, 1);
    check("post_rst_alu_ready", alu_ready, 1);

    // Simple ALU bypass, with the destination issued beforehand.
    iss_valid = 1; iss_rd = 5'd5;
    tick();
    check("iss5_pending", pending, 32'h0000_0020);
    iss_valid = 0;
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'h1234;
    tick();
    check("alu_we", we, 1);
    check("alu_reg_sel", reg_sel, 1);
    check("alu_addr", wr_addr, 5);
    check("alu_data", wr_data, 32'h1234);
    alu_valid = 0;
    tick();
    check("alu_done_we", we, 0);
    check("alu_pending_clr", pending, 0);

    // Load beats ALU; ALU result follows from the FIFO.
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'hA;
    lsu_valid = 1; lsu_rd = 5'd4; lsu_rdata = 32'h80FF_0000; lsu_funct3 = 3'b000; lsu_byte_off = 2'd3;
    tick();
    check("arb_load_addr", wr_addr, 4);
    check("arb_load_data", wr_data, 32'hFFFF_FF80);
    idle_inputs();
    tick();
    check("arb_alu_we", we, 1);
    check("arb_alu_addr", wr_addr, 3);
    check("arb_alu_data", wr_data, 32'hA);
    tick();
    check("arb_idle_we", we, 0);

    // Load extension.
    do_load("ld_lh2",  3'b001, 2'd2, 32'h8001_7FFE, 32'hFFFF_8001);
    do_load("ld_lhu2", 3'b101, 2'd2, 32'h8001_7FFE, 32'h0000_8001);
    do_load("ld_lbu0", 3'b100, 2'd0, 32'h8001_7FFE, 32'h0000_00FE);
    do_load("ld_f3_011", 3'b011, 2'd0, 32'h8001_7FFE, 32'h8001_7FFE);
    do_load("ld_lb0",  3'b000, 2'd0, 32'h8001_7FFE, 32'hFFFF_FFFE);
    do_load("ld_lh3",  3'b001, 2'd3, 32'h8001_7FFE, 32'hFFFF_8001);
    do_load("ld_lw",   3'b010, 2'd1, 32'h8001_7FFE, 32'h8001_7FFE);

    // Sustained loads fill the FIFO; ALU results then drain in order.
    for (int k = 0; k < 5; k++) begin
      exp_rd[k]   = 5'(11 + k);
      exp_data[k] = 32'h100 + k;
    end
    sent = 0;
    for (int i = 0; i < 6; i++) begin
      lsu_valid = 1; lsu_rd = 5'd10; lsu_funct3 = 3'b010; lsu_byte_off = 0;
      lsu_rdata = 32'hCAFE_0000 + i;
      alu_valid = 1; alu_rd = exp_rd[sent]; alu_data = exp_data[sent];
      rdy = alu_ready;
      check($sformatf("fill_ready_%0d", i), rdy, (i < 4) ? 1 : 0);
      if (rdy) sent++;
      tick();
      check($sformatf("fill_ld_addr_%0d", i), wr_addr, 10);
      check($sformatf("fill_ld_data_%0d", i), wr_data, 32'hCAFE_0000 + i);
    end
    lsu_valid = 0;
    drained = 0;
    for (int i = 0; i < 12; i++) begin
      alu_valid = (sent < 5);
      if (sent < 5) begin
        alu_rd = exp_rd[sent]; alu_data = exp_data[sent];
      end
      if (alu_valid && alu_ready) sent++;
      tick();
      if (we) begin
        if (drained < 5) begin
          check($sformatf("drain_addr_%0d", drained), wr_addr, exp_rd[drained]);
          check($sformatf("drain_data_%0d", drained), wr_data, exp_data[drained]);
        end else begin
          check("drain_extra_write", we, 0);
        end
        drained++;
      end
    end
    alu_valid = 0;
    check("drain_count", drained, 5);

    // Scoreboard timing and same-edge set/clear.
    reset = 1; tick(); reset = 0;
    iss_valid = 1; iss_rd = 5'd7;
    tick();
    check("sb_c1", pending[7], 1);
    iss_valid = 0;
    tick();
    check("sb_c2", pending[7], 1);
    tick();
    check("sb_c3", pending[7], 1);
    alu_valid = 1; alu_rd = 5'd7; alu_data = 32'h77;
    tick();
    check("sb_c4", pending[7], 1);
    check("sb_c4_we", we, 1);
    alu_valid = 0;
    tick();
    check("sb_c5_clear", pending, 0);
    iss_valid = 1; iss_rd = 5'd7;
    tick();
    alu_valid = 1; alu_rd = 5'd7; alu_data = 32'h78;
    iss_valid = 0;
    tick();
    check("sb_commit_we", we, 1);
    alu_valid = 0;
    iss_valid = 1; iss_rd = 5'd7;
    tick();
    check("sb_set_wins", pending, 32'h0000_0080);
    iss_rd = 5'd0;
    tick();
    check("sb_x0", pending, 32'h0000_0080);
    iss_valid = 0;

    // rd=0 results never write.
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'hFFFF;
    tick();
    check("alu_rd0_we", we, 0);
    alu_valid = 0;
    lsu_valid = 1; lsu_rd = 5'd0; lsu_rdata = 32'h1;
    tick();
    check("lsu_rd0_we", we, 0);
    lsu_valid = 0;
    tick();
    check("rd0_idle_we", we, 0);

    // Reset with three buffered ALU results discards them.
    for (int i = 0; i < 3; i++) begin
      lsu_valid = 1; lsu_rd = 5'd20; lsu_rdata = 32'h5; lsu_funct3 = 3'b010;
      alu_valid = 1; alu_rd = 5'(21 + i); alu_data = 32'h200 + i;
      tick();
    end
    idle_inputs();
    reset = 1;
    tick();
    check("rst_mid_we", we, 0);
    tick();
    reset = 0;
    #1;
    check("rst_mid_alu_ready", alu_ready, 1);
    check("rst_mid_pending", pending, 0);
    writes = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (we) writes++;
    end
    check("rst_mid_no_writes", writes, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rv_wb_unit.md
Name: rv_wb_unit

Overview:
- Writeback stage and the producer side of the integer register file's write port. It drives wr_data, wr_addr, we and reg_sel into the register file.
- Merges single-cycle ALU results and load data from the LSU. ALU results pass through a small buffer; load data is sign- or zero-extended here.
- Keeps a pending-write scoreboard that the fetch/decode unit uses to stall on RAW hazards.

Parameters:
- XLEN, 32, datapath width.
- ALU_FIFO_DEPTH, 4, ALU result buffer entries (power of 2, >=2).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- alu_valid  input  1  ALU result offered.
- alu_ready  output  1  = !fifo_full (no same-cycle pop look-ahead).
- alu_rd  input  5  ALU destination register.
- alu_data  input  XLEN  ALU result.
- lsu_valid  input  1  load data offered.
- lsu_ready  output  1  constant 1 outside reset; loads are never back-pressured.
- lsu_rd  input  5  load destination register.
- lsu_rdata  input  XLEN  raw aligned memory word.
- lsu_funct3  input  3  load type.
- lsu_byte_off  input  2  address[1:0] of the load.
- iss_valid  input  1  instruction with rd issued this cycle.
- iss_rd  input  5  its destination register.
- pending  output  32  scoreboard; bit i=1 means a write to xi is outstanding.
- wr_data  output  XLEN  register file write data.
- wr_addr  output  5  register file write address.
- we  output  1  register file write enable.
- reg_sel  output  1  integer register file select; equals we.

Behaviour:
- Reset (sync, high): FIFO emptied; we=0, reg_sel=0, wr_addr=0, wr_data=0, pending=0, lsu_ready=0. A reset mid-operation discards all buffered and in-flight results.
- Output port is registered. A result selected at edge N drives we=1 from N to N+1; the register file commits at edge N+1.
- Per-cycle selection, in priority order:
  1. lsu_valid=1: extended load is selected.
  2. Else FIFO not empty: FIFO head is popped and selected.
  3. Else alu_valid & alu_ready: ALU input bypasses the FIFO and is selected directly (1-cycle latency).
  4. Else the output register loads we=0.
- An accepted ALU result that is not selected that cycle is pushed to the FIFO. Push and pop in the same cycle are legal; FIFO is in-order, with pointers that wrap at ALU_FIFO_DEPTH.
- rd=0 results are accepted and consumed but produce we=0. They never enter the FIFO.
- Load extension by lsu_funct3 (byte = lsu_rdata[8*off +: 8]; half = lsu_rdata[16*off[1] +: 16], off[0] ignored):
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - Any other code: treated as LW.
- Scoreboard:
  - iss_valid & iss_rd!=0 sets pending[iss_rd] at the edge.
  - A committing write (we=1 at the edge) clears pending[wr_addr].
  - Set and clear of the same bit at the same edge: set wins.
  - pending[0] is hard-wired to 0.
- FIFO full: alu_ready=0 and the upstream ALU holds its data. Sustained lsu_valid starves ALU writes; this is intended, and the LSU never issues more than 1 load per 2 cycles.

Decomposition:
- Package rv_wb_pkg holds:
  - XLEN default.
  - Load funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - wb_entry_t struct {rd[4:0], data[XLEN-1:0]}.
- Sub-module rv_wb_fifo is a synchronous FIFO of wb_entry_t with push/pop/full/empty. The top module keeps the arbitration, the load extender and the scoreboard.

Test Plan:
- Reset, then one cycle of alu_valid with rd=5, data=0x1234 into an empty FIFO -> next cycle we=1, reg_sel=1, wr_addr=5, wr_data=0x1234; pending=0 afterwards if issued earlier.
- lsu_valid and alu_valid in the same cycle (ALU rd=3, data=0xA; LB rd=4, rdata=0x80FF0000, off=3) -> first write is x4=0xFFFFFF80, next cycle x3=0xA.
- Load extension with rdata=0x8001_7FFE:
  - LH off=2 -> 0xFFFF8001.
  - LHU off=2 -> 0x00008001.
  - LBU off=0 -> 0x000000FE.
  - funct3=011 -> 0x80017FFE.
- Hold lsu_valid high for 6 cycles while sending 5 ALU results -> alu_ready falls after 4 are buffered; ALU writes then drain in order with no loss or duplication.
- iss_rd=7 at cycle 0, ALU result rd=7 at cycle 3 -> pending[7] is 1 in cycles 1-4 and clears after the commit edge. Issue of rd=7 on that same edge -> pending[7] stays 1.
- ALU result with rd=0 -> we stays 0. Reset asserted with the FIFO holding 3 entries -> no writes after reset, and alu_ready=1 once reset is released.
